and_gate_checker: RTL and testbench

- Self-checking exerciser for a two-input AND gate: drives the gate's inputs and reads back its output.
- On `start`, sweeps all four {a,b} vectors for LOOPS passes. For each vector it waits a settle interval, samples the returned output and compares it with a&b.
- Reports busy/done, a pass flag, an error count and a sticky per-vector failure mask.
- Sits in the lab top level between the debounced start button and the gate under test; results drive the board LEDs.

---
 rtl/and_gate_checker.sv | 125 ++++++++++++
 tb/tb_and_gate_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_checker.sv
// and_gate_checker: drives a two-input AND gate through all four input
// vectors for LOOPS sweeps, then reports busy/done, a pass flag, a saturating
// mismatch count and a sticky per-vector failure mask.
module and_gate_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS         = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic             x_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LOOP_W-1:0] LOOP_LAST = LOOP_W'(LOOPS - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        idx;
  logic [LOOP_W-1:0] loop_cnt;
  logic [CNT_W-1:0]  cnt;
  logic              last_vec;
  logic              mismatch;

  assign last_vec = (idx == 2'd3) && (loop_cnt == LOOP_LAST);
  assign mismatch = (x_in != (a_out & b_out));

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and the combinational done pulse.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (cnt == CNT_LAST) state_next = SAMPLE;
      SAMPLE:  state_next = last_vec ? DONE : SETTLE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Vector drive, settle timing, result accumulation and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= 1'b0;
      b_out     <= 1'b0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      idx       <= '0;
      loop_cnt  <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            {a_out, b_out} <= 2'b00;
            idx       <= '0;
            loop_cnt  <= '0;
            cnt       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == CNT_LAST) cnt <= '0;
          else                 cnt <= cnt + CNT_W'(1);
        end
        SAMPLE: begin
          if (mismatch) begin
            fail_vec[idx] <= 1'b1;
            if (err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
          end
          if (!last_vec) begin
            if (idx == 2'd3) begin
              loop_cnt       <= loop_cnt + LOOP_W'(1);
              idx            <= 2'd0;
              {a_out, b_out} <= 2'b00;
            end else begin
              idx            <= idx + 2'd1;
              {a_out, b_out} <= idx + 2'd1;
            end
          end
        end
        DONE: begin
          busy           <= 1'b0;
          pass           <= (err_count == '0);
          {a_out, b_out} <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_and_gate_checker.sv
// tb_and_gate_checker: three checker instances (LOOPS = 1, 3, 8) each
// exercising a modelled gate; table-driven fault cases, hand sequences for
// reset/start corner cases, and randomized per-vector fault runs.
module tb_and_gate_checker;

  logic       clk;
  logic       rst_n;
  logic       start_s [3];
  logic       a_s     [3];
  logic       b_s     [3];
  logic       x_s     [3];
  logic       busy_s  [3];
  logic       done_s  [3];
  logic       pass_s  [3];
  logic [3:0] err_s   [3];
  logic [3:0] fail_s  [3];
  int         mode_s  [3];
  logic       seq_x   [3];

  int n_vec = 0;
  int n_bad = 0;

  and_gate_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a_out(a_s[0]), .b_out(b_s[0]),
    .x_in(x_s[0]), .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
    .err_count(err_s[0]), .fail_vec(fail_s[0]));

  and_gate_checker #(.SETTLE_CYCLES(2), .LOOPS(3), .ERR_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a_out(a_s[1]), .b_out(b_s[1]),
    .x_in(x_s[1]), .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
    .err_count(err_s[1]), .fail_vec(fail_s[1]));

  and_gate_checker #(.SETTLE_CYCLES(2), .LOOPS(8), .ERR_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .a_out(a_s[2]), .b_out(b_s[2]),
    .x_in(x_s[2]), .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]),
    .err_count(err_s[2]), .fail_vec(fail_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gate models: 0 ideal AND, 1 stuck-at-0, 2 stuck-at-1, 3 OR, 4 AND with per-vector flips
  function automatic logic gate_fn(input int mode, input logic [1:0] v, input logic [3:0] flip);
    case (mode)
      0:       return v[1] & v[0];
      1:       return 1'b0;
      2:       return 1'b1;
      3:       return v[1] | v[0];
      default: return (v[1] & v[0]) ^ flip[v];
    endcase
  endfunction

  function automatic int loops_of(input int inst);
    case (inst)
      0:       return 1;
      1:       return 3;
      default: return 8;
    endcase
  endfunction

  // Gate under test seen by each checker; mode 4 is driven cycle by cycle from the bench
  always_comb begin
    for (int i = 0; i < 3; i++)
      x_s[i] = (mode_s[i] == 4) ? seq_x[i] : gate_fn(mode_s[i], {a_s[i], b_s[i]}, 4'b0000);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One run on instance inst; checks every cycle against a timing/result model
  task automatic applyStimulus(input int inst, input int mode, input logic [3:0] flip,
                               input bit noise, input bit hold, input bit prestarted,
                               output logic rp, output logic [3:0] re, output logic [3:0] rf);
    int         nl;
    int         n;
    int         errs;
    logic [3:0] fv;
    logic [1:0] v;
    nl   = loops_of(inst);
    n    = 4 * nl * 3 + 1;
    errs = 0;
    fv   = 4'b0000;
    for (int l = 0; l < nl; l++)
      for (int k = 0; k < 4; k++) begin
        v = 2'(k);
        if (gate_fn(mode, v, flip) != (v == 2'd3)) begin
          errs++;
          fv[v] = 1'b1;
        end
      end
    mode_s[inst] = mode;
    if (!prestarted) start_s[inst] = 1'b1;
    rp = 1'b0;
    re = 4'd0;
    rf = 4'd0;
    for (int j = 1; j <= n + 1; j++) begin
      @(negedge clk);
      v = 2'(((j - 1) / 3) % 4);
      if (j < n) begin
        checkOutput($sformatf("i%0d c%0d busy", inst, j), int'(busy_s[inst]), 1);
        checkOutput($sformatf("i%0d c%0d done", inst, j), int'(done_s[inst]), 0);
        checkOutput($sformatf("i%0d c%0d vec", inst, j), int'({a_s[inst], b_s[inst]}), int'(v));
      end
      if (j == 1) begin
        checkOutput($sformatf("i%0d start pass", inst), int'(pass_s[inst]), 0);
        checkOutput($sformatf("i%0d start err", inst), int'(err_s[inst]), 0);
        checkOutput($sformatf("i%0d start fail_vec", inst), int'(fail_s[inst]), 0);
      end
      if (j == n)
        checkOutput($sformatf("i%0d c%0d done", inst, j), int'(done_s[inst]), 1);
      if (j == n + 1) begin
        checkOutput($sformatf("i%0d end done", inst), int'(done_s[inst]), 0);
        checkOutput($sformatf("i%0d end busy", inst), int'(busy_s[inst]), 0);
        checkOutput($sformatf("i%0d end vec", inst), int'({a_s[inst], b_s[inst]}), 0);
        checkOutput($sformatf("i%0d end pass", inst), int'(pass_s[inst]), (errs == 0) ? 1 : 0);
        checkOutput($sformatf("i%0d end err", inst), int'(err_s[inst]), (errs > 15) ? 15 : errs);
        checkOutput($sformatf("i%0d end fail_vec", inst), int'(fail_s[inst]), int'(fv));
        rp = pass_s[inst];
        re = err_s[inst];
        rf = fail_s[inst];
      end
      start_s[inst] = hold ? 1'b1 : (noise && (j == 3 || j == 12 || j == n));
      if (mode == 4)
        seq_x[inst] = ((j % 3 == 0) && (j < n)) ? ((v == 2'd3) ^ flip[v]) : 1'($urandom);
    end
  endtask

  typedef struct {
    int         inst;
    int         mode;
    logic       exp_pass;
    logic [3:0] exp_err;
    logic [3:0] exp_fail;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic       rp;
    logic [3:0] re;
    logic [3:0] rf;
    int         inst;

    tbl[0] = '{inst: 0, mode: 0, exp_pass: 1'b1, exp_err: 4'd0,  exp_fail: 4'b0000};
    tbl[1] = '{inst: 0, mode: 1, exp_pass: 1'b0, exp_err: 4'd1,  exp_fail: 4'b1000};
    tbl[2] = '{inst: 0, mode: 2, exp_pass: 1'b0, exp_err: 4'd3,  exp_fail: 4'b0111};
    tbl[3] = '{inst: 1, mode: 3, exp_pass: 1'b0, exp_err: 4'd6,  exp_fail: 4'b0110};
    tbl[4] = '{inst: 2, mode: 2, exp_pass: 1'b0, exp_err: 4'd15, exp_fail: 4'b0111};
    tbl[5] = '{inst: 2, mode: 0, exp_pass: 1'b1, exp_err: 4'd0,  exp_fail: 4'b0000};

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      seq_x[i]   = 1'b0;
      mode_s[i]  = 0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset vec", int'({a_s[0], b_s[0]}), 0);
    checkOutput("reset busy", int'(busy_s[0]), 0);
    checkOutput("reset done", int'(done_s[0]), 0);
    checkOutput("reset pass", int'(pass_s[0]), 0);
    checkOutput("reset err", int'(err_s[0]), 0);
    checkOutput("reset fail_vec", int'(fail_s[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      applyStimulus(tbl[t].inst, tbl[t].mode, 4'b0000, 1'b0, 1'b0, 1'b0, rp, re, rf);
      checkOutput($sformatf("tbl%0d pass", t), int'(rp), int'(tbl[t].exp_pass));
      checkOutput($sformatf("tbl%0d err", t), int'(re), int'(tbl[t].exp_err));
      checkOutput($sformatf("tbl%0d fail_vec", t), int'(rf), int'(tbl[t].exp_fail));
    end

    // Start pulses during SETTLE/SAMPLE/DONE are ignored: exactly one done at cycle 13
    applyStimulus(0, 0, 4'b0000, 1'b1, 1'b0, 1'b0, rp, re, rf);

    // Start held high: back-to-back runs, prior stuck-at-1 results cleared on the new accept
    applyStimulus(0, 2, 4'b0000, 1'b0, 1'b1, 1'b0, rp, re, rf);
    applyStimulus(0, 0, 4'b0000, 1'b0, 1'b0, 1'b1, rp, re, rf);

    // Asynchronous reset in cycle 5 of a failing run clears everything immediately
    mode_s[0]  = 2;
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("pre-reset err", int'(err_s[0]), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun reset vec", int'({a_s[0], b_s[0]}), 0);
    checkOutput("midrun reset busy", int'(busy_s[0]), 0);
    checkOutput("midrun reset done", int'(done_s[0]), 0);
    checkOutput("midrun reset pass", int'(pass_s[0]), 0);
    checkOutput("midrun reset err", int'(err_s[0]), 0);
    checkOutput("midrun reset fail_vec", int'(fail_s[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, rp, re, rf);
    checkOutput("post-reset pass", int'(rp), 1);

    // Randomized per-vector faults with random x_in outside SAMPLE cycles
    for (int r = 0; r < 10; r++) begin
      inst = int'($urandom_range(0, 2));
      applyStimulus(inst, 4, 4'($urandom), 1'($urandom), 1'b0, 1'b0, rp, re, rf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
